// File: rtl/div_unit_if.sv
// EX-stage division request/response bundle: EX drives the master side,
// the iterative divider answers on the slave side.
interface div_unit_if #(
   parameter int WIDTH = 32
);
   logic                   signed_div_i;
   logic [WIDTH-1:0]       opdata1_i;
   logic [WIDTH-1:0]       opdata2_i;
   logic                   start_i;
   logic                   annul_i;
   logic [2*WIDTH-1:0]     result_o;
   logic                   ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider producing {remainder, quotient} for DIV/DIVU.
// Optional macro DIV_EARLY_OUT_EN: finish at the start edge when |dividend| < |divisor|.
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic       clk,
   input logic       rst,
   div_unit_if.slave div_if
);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [2*WIDTH-1:0]   part_q;
   logic [WIDTH-1:0]     dvs_q;
   logic                 sgn_q;
   logic                 a_neg_q;
   logic                 b_neg_q;
   logic [2*WIDTH-1:0]   result_q;
   logic                 ready_q;

   logic [2*WIDTH:0]     shift_d;
   logic                 ge_d;
   logic [WIDTH-1:0]     diff_d;
   logic [2*WIDTH-1:0]   part_d;
   logic [WIDTH-1:0]     mag_a_d;
   logic [WIDTH-1:0]     mag_b_d;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic en);
      logic signed [WIDTH-1:0] vs;
      vs = signed'(v);
      return (en && vs < 0) ? unsigned'(-vs) : v;
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   assign mag_a_d = magnitude(div_if.opdata1_i, div_if.signed_div_i);
   assign mag_b_d = magnitude(div_if.opdata2_i, div_if.signed_div_i);

   // One restoring step: the remainder is always below the divisor, so when the
   // trial succeeds the difference fits in WIDTH bits and the extra top bit only
   // matters for the comparison.
   always_comb begin
      shift_d = {part_q, 1'b0};
      ge_d    = shift_d[2*WIDTH:WIDTH] >= {1'b0, dvs_q};
      diff_d  = shift_d[2*WIDTH-1:WIDTH] - dvs_q;
      part_d  = shift_d[2*WIDTH-1:0];
      if (ge_d) begin
         part_d = {diff_d, shift_d[WIDTH-1:1], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FREE;
         cnt_q    <= '0;
         part_q   <= '0;
         dvs_q    <= '0;
         sgn_q    <= 1'b0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else if (div_if.annul_i) begin
         state_q  <= FREE;
         cnt_q    <= '0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         case (state_q)
            FREE: begin
               result_q <= '0;
               ready_q  <= 1'b0;
               if (div_if.start_i) begin
                  if (div_if.opdata2_i == '0) begin
                     state_q <= BYZERO;
`ifdef DIV_EARLY_OUT_EN
                  end else if (mag_a_d < mag_b_d) begin
                     result_q <= {div_if.opdata1_i, {WIDTH{1'b0}}};
                     ready_q  <= 1'b1;
                     state_q  <= END;
`endif
                  end else begin
                     part_q  <= {{WIDTH{1'b0}}, mag_a_d};
                     dvs_q   <= mag_b_d;
                     sgn_q   <= div_if.signed_div_i;
                     a_neg_q <= div_if.opdata1_i[WIDTH-1];
                     b_neg_q <= div_if.opdata2_i[WIDTH-1];
                     cnt_q   <= '0;
                     state_q <= ON;
                  end
               end
            end
            BYZERO: begin
               result_q <= '0;
               ready_q  <= 1'b1;
               state_q  <= END;
            end
            ON: begin
               if (cnt_q == CNT_W'(WIDTH)) begin
                  // Remainder follows the dividend sign, quotient the sign product.
                  result_q <= {apply_sign(part_q[2*WIDTH-1:WIDTH], sgn_q & a_neg_q),
                               apply_sign(part_q[WIDTH-1:0], sgn_q & (a_neg_q ^ b_neg_q))};
                  ready_q  <= 1'b1;
                  state_q  <= END;
               end else begin
                  part_q <= part_d;
                  cnt_q  <= cnt_q + 1'b1;
               end
            end
            END: begin
               if (!div_if.start_i) begin
                  result_q <= '0;
                  ready_q  <= 1'b0;
                  state_q  <= FREE;
               end
            end
            default: state_q <= FREE;
         endcase
      end
   end

   assign div_if.result_o = result_q;
   assign div_if.ready_o  = ready_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Iterative radix-2 restoring divider. It is the responder for the EX-stage division request interface (sign select, two operands, start level, ready/result return). It computes a 64-bit {remainder, quotient} for DIV/DIVU, which EX writes into HI/LO. It sits beside EX in the pipeline; EX stalls the pipeline while the result is not ready.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH.
CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU)
opdata1_i  input  WIDTH  dividend
opdata2_i  input  WIDTH  divisor
start_i  input  1  level request; held high by EX until ready_o is seen
annul_i  input  1  abort the current operation (pipeline flush)
result_o  output  2*WIDTH  {remainder[63:32], quotient[31:0]}; maps to HI = remainder, LO = quotient
ready_o  output  1  result_o valid

Behaviour:
- Reset: rst is sampled on clk only. It forces state=FREE, cnt=0, result_o=0, ready_o=0 and clears internal registers. rst overrides every other input, including an operation in progress.
- States: FREE, BYZERO, ON, END. Registered outputs change only on clk edges.
- Edge E0 (FREE, start_i=1, annul_i=0):
  - divisor==0 -> go to BYZERO.
  - otherwise latch the operand magnitudes: two's-complement negate an operand only if signed_div_i=1 and its MSB=1. Latch the signs and signed_div_i, set cnt=0, go to ON.
  - Operand or sign changes after E0 are ignored until the next operation.
- BYZERO: on the next edge (E1), go to END with result_o=0 and ready_o=1.
- ON: one iteration per edge, E1..E32.
  - Shift the 65-bit partial register {rem, quot} left by 1.
  - Trial-subtract the divisor magnitude from the upper part.
  - If the trial is non-negative, keep the difference and set the quotient LSB to 1; otherwise restore and set the LSB to 0.
  - cnt increments each iteration.
  - When cnt==WIDTH (edge E33), apply sign correction and go to END.
- Sign correction (signed only):
  - Quotient is negated if the dividend sign differs from the divisor sign.
  - Remainder is negated if the dividend was negative; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000 and remainder 0, with no exception.
- END: result_o is held and ready_o=1.
  - Stay in END while start_i=1.
  - When start_i=0, go to FREE on the next edge and set ready_o=0 and result_o=0 on that same edge.
- Latency: ready_o is first visible in the cycle after E33 (33 edges after the start-sampling edge). Divide-by-zero is visible after E1.
- annul_i=1 in any state other than reset: next edge goes to FREE with ready_o=0, result_o=0, cnt=0. annul_i has priority over start_i. In FREE, annul_i with start_i blocks the start.
- start_i dropped mid-ON without annul_i: the operation continues to END. It then returns to FREE on the next edge because start_i=0.
- A new start is accepted only in FREE, so there is a minimum of one FREE cycle between operations.

Optional Feature:
Macro DIV_EARLY_OUT_EN.
- Defined: at E0, if divisor!=0 and |dividend| < |divisor| (magnitudes compared unsigned), go directly to END with quotient=0 and remainder=original dividend. ready_o is visible after E0, a latency of 1 edge.
- Not defined: every non-zero-divisor operation takes the full 33-edge path.
- Results are identical either way; only latency differs.

Test Plan:
- Unsigned 100/7, start held -> ready_o high exactly 33 edges after E0, result_o=0x00000002_0000000E. Drop start -> ready_o=0 and result_o=0 one edge later.
- Signed 0xFFFFFFF9 (-7) / 2 -> result_o=0xFFFFFFFF_FFFFFFFD. Signed 7 / 0xFFFFFFFE (-2) -> 0x00000001_FFFFFFFD. Signed 0x80000000 / 0xFFFFFFFF -> 0x00000000_80000000.
- Divisor 0 with dividend 0x12345678 -> ready_o after E1, result_o=0.
- annul_i pulsed 10 edges after E0 -> ready_o never rises, FREE next edge. Then 9/3 unsigned -> 0x00000000_00000003 after 33 edges.
- rst asserted mid-ON and start/operand changes mid-ON -> rst clears all outputs next edge. The operand changes do not affect the in-flight result (200/10 stays 0x00000000_00000014).
- DIV_EARLY_OUT_EN defined, unsigned 5/9 -> ready after E0, result_o=0x00000005_00000000. Undefined -> same result after 33 edges.
